instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Multicycle instruction-fetch unit: the consumer of the program counter. On a start pulse from the control FSM it samples the current PC, issues one read on the instruction-memory request/response interface, and latches the returned word into the instruction register with the PC it was fetched from. It also provides PC+4 as the sequential next-PC candidate. It sits between the program counter, instruction memory and the multicycle control FSM.

## Interface
Parameters:
- XLEN, 32, data and address width
- RESET_INSTR, 32'h00000013, instruction-register value after reset (addi x0,x0,0)

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- fetch_start  in  1  control FSM request to fetch at `pc`; honoured only in IDLE
- pc  in  XLEN  current program counter value
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  read address, stable while mem_req_valid=1
- mem_rsp_valid  in  1  response valid (single cycle)
- mem_rsp_data  in  XLEN  fetched instruction word
- mem_rsp_err  in  1  bus error on this response
- instr  out  XLEN  instruction register
- old_pc  out  XLEN  address of the word in `instr`
- pc_plus4  out  XLEN  old_pc + 4
- fetch_done  out  1  one-cycle completion pulse
- fetch_err  out  1  error, valid only while fetch_done=1
- err_cause  out  2  00 none, 01 misaligned, 10 bus error; valid with fetch_done
- busy  out  1  1 in any state other than IDLE

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: fetch_start=1 -> capture pc into address register and old_pc-candidate; go REQ.
- REQ: mem_req_valid=1, mem_addr=captured pc. On mem_req_valid & mem_req_ready -> WAIT. Request held unchanged until accepted (no timeout).
- WAIT: mem_req_valid=0. On mem_rsp_valid: if mem_rsp_err=0, instr<=mem_rsp_data, old_pc<=captured pc, err_cause<=00; if 1, instr and old_pc unchanged, err_cause<=10. Go DONE.
- DONE: fetch_done=1, fetch_err=(err_cause!=00) for exactly one cycle; go IDLE.
- fetch_start outside IDLE is ignored (not queued). mem_rsp_valid outside WAIT is ignored.
- pc_plus4 = old_pc + 4 modulo 2^XLEN; old_pc=32'hFFFFFFFC gives pc_plus4=0.
- Exactly one outstanding request at any time.

## Timing
- Reset values: mem_req_valid=0, mem_addr=0, instr=RESET_INSTR, old_pc=0, pc_plus4=4, fetch_done=0, fetch_err=0, err_cause=00, busy=0, state IDLE.
- Reset mid-fetch: request dropped immediately (asynchronously); any later response ignored.
- Registered outputs only; no combinational path from memory inputs to outputs.
- Minimum latency with zero-wait memory: fetch_start in cycle 0; REQ in cycle 1 (accepted); WAIT in cycle 2 (response); fetch_done in cycle 3. Each ready stall or response delay cycle adds one.
- instr/old_pc/pc_plus4 are updated at the edge entering DONE and are stable while fetch_done=1; the PC may be overwritten in that same cycle.
- fetch_start asserted in the DONE cycle is ignored; next accepted start is the first IDLE cycle.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: in IDLE, fetch_start with pc[1:0]!=00 skips REQ/WAIT and goes directly to DONE next cycle, err_cause=01, fetch_err=1, no memory request, instr/old_pc unchanged.
- Not defined: no alignment check; pc goes to mem_addr unchanged and err_cause 01 is never produced.

## Test plan
- Reset then zero-wait fetch at pc=0x00000010, rsp_data=0x00500093 -> fetch_done in cycle 3, instr=0x00500093, old_pc=0x10, pc_plus4=0x14, fetch_err=0.
- mem_req_ready held low for 4 cycles -> mem_req_valid stays 1 with mem_addr constant, then fetch_done exactly 4 cycles later than zero-wait.
- Response with mem_rsp_err=1 -> fetch_done with fetch_err=1, err_cause=10, instr and old_pc retain previous values.
- old_pc=0xFFFFFFFC fetch -> pc_plus4=0x00000000; fetch_start pulsed during WAIT -> ignored, exactly one request issued.
- reset asserted in WAIT, response arrives after release -> outputs at reset values, no fetch_done, busy=0.
- With FETCH_ALIGN_CHECK_EN, pc=0x00000006 -> no mem_req_valid, fetch_done next cycle, err_cause=01; without it, mem_addr=0x00000006 requested.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle instruction fetch.
// On fetch_start in IDLE the unit samples pc and issues one read on the
// instruction-memory request/response interface. The returned word is latched
// into instr together with the address it came from (old_pc). pc_plus4 is the
// sequential next-PC candidate.
// Optional feature: define FETCH_ALIGN_CHECK_EN to reject fetches whose pc is
// not word aligned. Such a fetch completes with err_cause=01 and issues no
// memory request.
module instr_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_start,
    input  logic [XLEN-1:0] pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_done,
    output logic            fetch_err,
    output logic [1:0]      err_cause,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERROR = 2'b10;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] old_pc_q, old_pc_d;
    logic [1:0]      err_cause_q, err_cause_d;

    // Next-state and datapath update for the fetch sequence
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        old_pc_d    = old_pc_q;
        err_cause_d = err_cause_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    // addr_q doubles as the old_pc candidate until the response returns
                    addr_d = pc;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        state_d     = S_DONE;
                        err_cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    if (mem_rsp_err) begin
                        // instr/old_pc keep the last good fetch on a bus error
                        err_cause_d = CAUSE_BUS_ERROR;
                    end else begin
                        instr_d     = mem_rsp_data;
                        old_pc_d    = addr_q;
                        err_cause_d = CAUSE_NONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously so a reset mid-fetch drops the request at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            instr_q     <= RESET_INSTR;
            old_pc_q    <= '0;
            err_cause_q <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            old_pc_q    <= old_pc_d;
            err_cause_q <= err_cause_d;
        end
    end

    // All outputs are decoded from registers only; memory inputs never reach them combinationally
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = addr_q;
    assign instr         = instr_q;
    assign old_pc        = old_pc_q;
    assign pc_plus4      = old_pc_q + XLEN'(4);
    assign fetch_done    = (state_q == S_DONE);
    assign fetch_err     = (state_q == S_DONE) && (err_cause_q != CAUSE_NONE);
    assign err_cause     = err_cause_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// Inputs change 1 time unit after each rising edge; outputs are checked at the
// same point, away from the active edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [31:0] pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        fetch_err;
    logic [1:0]  err_cause;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int req_cnt  = 0;
    int req_base;

    instr_fetch_unit #(.XLEN(32), .RESET_INSTR(32'h00000013)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_start   (fetch_start),
        .pc            (pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .instr         (instr),
        .old_pc        (old_pc),
        .pc_plus4      (pc_plus4),
        .fetch_done    (fetch_done),
        .fetch_err     (fetch_err),
        .err_cause     (err_cause),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Count accepted memory requests (handshake seen at the edge)
    always @(posedge clk) begin
        if (reset && mem_req_valid && mem_req_ready) req_cnt <= req_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b0;
        fetch_start   = 1'b0;
        pc            = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h00000013);
        chk("rst_old_pc", old_pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_fetch_done", 32'(fetch_done), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_err_cause", 32'(err_cause), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // Zero-wait fetch at 0x10
        fetch_start   = 1'b1;
        pc            = 32'h00000010;
        mem_req_ready = 1'b1;
        tick();
        chk("t1_c1_req_valid", 32'(mem_req_valid), 32'd1);
        chk("t1_c1_mem_addr", mem_addr, 32'h10);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        fetch_start = 1'b0;
        tick();
        chk("t1_c2_req_valid", 32'(mem_req_valid), 32'd0);
        chk("t1_c2_done", 32'(fetch_done), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00500093;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t1_c3_done", 32'(fetch_done), 32'd1);
        chk("t1_c3_instr", instr, 32'h00500093);
        chk("t1_c3_old_pc", old_pc, 32'h10);
        chk("t1_c3_pc_plus4", pc_plus4, 32'h14);
        chk("t1_c3_fetch_err", 32'(fetch_err), 32'd0);
        chk("t1_c3_err_cause", 32'(err_cause), 32'd0);
        tick();
        chk("t1_c4_done", 32'(fetch_done), 32'd0);
        chk("t1_c4_busy", 32'(busy), 32'd0);

        // Four ready-stall cycles: done lands in cycle 7
        fetch_start   = 1'b1;
        pc            = 32'h00000020;
        mem_req_ready = 1'b0;
        tick();
        fetch_start = 1'b0;
        pc          = 32'h000000AA;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_req_valid", 32'(mem_req_valid), 32'd1);
            chk("t2_stall_mem_addr", mem_addr, 32'h20);
            tick();
        end
        chk("t2_c5_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        tick();
        chk("t2_c6_req_valid", 32'(mem_req_valid), 32'd0);
        chk("t2_c6_done", 32'(fetch_done), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00A00113;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t2_c7_done", 32'(fetch_done), 32'd1);
        chk("t2_c7_instr", instr, 32'h00A00113);
        chk("t2_c7_old_pc", old_pc, 32'h20);
        tick();

        // Bus error response; an early response during REQ is ignored
        fetch_start   = 1'b1;
        pc            = 32'h00000030;
        mem_req_ready = 1'b0;
        tick();
        fetch_start   = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        tick();
        chk("t3_early_rsp_req_valid", 32'(mem_req_valid), 32'd1);
        chk("t3_early_rsp_done", 32'(fetch_done), 32'd0);
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        chk("t3_done", 32'(fetch_done), 32'd1);
        chk("t3_fetch_err", 32'(fetch_err), 32'd1);
        chk("t3_err_cause", 32'(err_cause), 32'd2);
        chk("t3_instr_kept", instr, 32'h00A00113);
        chk("t3_old_pc_kept", old_pc, 32'h20);
        chk("t3_pc_plus4", pc_plus4, 32'h24);
        tick();
        chk("t3_fetch_err_gone", 32'(fetch_err), 32'd0);

        // Fetch at 0xFFFFFFFC, start pulses in WAIT and DONE are ignored
        req_base    = req_cnt;
        fetch_start = 1'b1;
        pc          = 32'hFFFFFFFC;
        tick();
        fetch_start = 1'b0;
        chk("t4_c1_mem_addr", mem_addr, 32'hFFFFFFFC);
        tick();
        fetch_start = 1'b1;
        pc          = 32'h00000040;
        tick();
        fetch_start = 1'b0;
        chk("t4_wait_busy", 32'(busy), 32'd1);
        chk("t4_wait_req_valid", 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00000033;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t4_done", 32'(fetch_done), 32'd1);
        chk("t4_old_pc", old_pc, 32'hFFFFFFFC);
        chk("t4_pc_plus4_wrap", pc_plus4, 32'h00000000);
        chk("t4_instr", instr, 32'h00000033);
        fetch_start = 1'b1;
        pc          = 32'h00000040;
        tick();
        fetch_start = 1'b0;
        chk("t4_done_start_ignored_busy", 32'(busy), 32'd0);
        chk("t4_done_start_ignored_valid", 32'(mem_req_valid), 32'd0);
        tick();
        chk("t4_single_request", 32'(req_cnt - req_base), 32'd1);

        // Reset asserted in WAIT, late response after release
        fetch_start = 1'b1;
        pc          = 32'h00000050;
        tick();
        fetch_start = 1'b0;
        tick();
        chk("t5_in_wait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_req_valid", 32'(mem_req_valid), 32'd0);
        chk("t5_async_instr", instr, 32'h00000013);
        chk("t5_async_old_pc", old_pc, 32'h0);
        tick();
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00001234;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t5_late_rsp_done", 32'(fetch_done), 32'd0);
        chk("t5_late_rsp_busy", 32'(busy), 32'd0);
        chk("t5_late_rsp_instr", instr, 32'h00000013);
        chk("t5_late_rsp_pc_plus4", pc_plus4, 32'h4);
        chk("t5_late_rsp_mem_addr", mem_addr, 32'h0);

        // Misaligned pc
        fetch_start = 1'b1;
        pc          = 32'h00000006;
        tick();
        fetch_start = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_no_req", 32'(mem_req_valid), 32'd0);
        chk("t6_done", 32'(fetch_done), 32'd1);
        chk("t6_err_cause", 32'(err_cause), 32'd1);
        chk("t6_fetch_err", 32'(fetch_err), 32'd1);
        chk("t6_instr_kept", instr, 32'h00000013);
        tick();
        chk("t6_idle", 32'(busy), 32'd0);
`else
        chk("t6_req_valid", 32'(mem_req_valid), 32'd1);
        chk("t6_mem_addr", mem_addr, 32'h00000006);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00000055;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t6_done", 32'(fetch_done), 32'd1);
        chk("t6_err_cause", 32'(err_cause), 32'd0);
        chk("t6_old_pc", old_pc, 32'h00000006);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
